// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder: pops bytes from the receiver FIFO, tracks E0/F0
// prefixes and shift, and reports the held key, its ASCII value and press events.
module ps2_scancode_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       ready,
  output logic       nextdata_n,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic [7:0] key_ascii,
  output logic       key_held,
  output logic       shift,
  output logic       key_press,
  output logic       key_release,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {FETCH, POP, SETTLE} fetch_t;
  typedef enum logic [1:0] {P_IDLE, P_EXT, P_BRK, P_EXTBRK} parse_t;

  fetch_t     state_q, state_d;
  parse_t     parse_q, parse_d;
  logic       pop_req;
  logic       vld_p0;
  logic [7:0] byte_p0;

  logic ext_c, brk_c, do_make, do_break, is_shift, match;
  logic new_press, do_release, shift_set, shift_clr;

  // Lowercase ASCII for set-2 letter codes, 0x00 for anything else.
  function automatic logic [7:0] letter_map(input logic [7:0] c);
    logic [7:0] r;
    case (c)
      8'h1C: r = 8'h61;  8'h32: r = 8'h62;  8'h21: r = 8'h63;  8'h23: r = 8'h64;
      8'h24: r = 8'h65;  8'h2B: r = 8'h66;  8'h34: r = 8'h67;  8'h33: r = 8'h68;
      8'h43: r = 8'h69;  8'h3B: r = 8'h6A;  8'h42: r = 8'h6B;  8'h4B: r = 8'h6C;
      8'h3A: r = 8'h6D;  8'h31: r = 8'h6E;  8'h44: r = 8'h6F;  8'h4D: r = 8'h70;
      8'h15: r = 8'h71;  8'h2D: r = 8'h72;  8'h1B: r = 8'h73;  8'h2C: r = 8'h74;
      8'h3C: r = 8'h75;  8'h2A: r = 8'h76;  8'h1D: r = 8'h77;  8'h22: r = 8'h78;
      8'h35: r = 8'h79;  8'h1A: r = 8'h7A;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] ascii_map(input logic [7:0] c, input logic ext,
                                           input logic sh);
    logic [7:0] r;
    logic [7:0] l;
    l = letter_map(c);
    case (c)
      8'h45: r = 8'h30;  8'h16: r = 8'h31;  8'h1E: r = 8'h32;  8'h26: r = 8'h33;
      8'h25: r = 8'h34;  8'h2E: r = 8'h35;  8'h36: r = 8'h36;  8'h3D: r = 8'h37;
      8'h3E: r = 8'h38;  8'h46: r = 8'h39;
      8'h29: r = 8'h20;  8'h5A: r = 8'h0D;  8'h66: r = 8'h08;
      default: r = (l != 8'h00 && sh) ? (l - 8'h20) : l;
    endcase
    if (ext) r = 8'h00;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (ready) state_d = POP;
      POP:     state_d = SETTLE;
      SETTLE:  state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    pop_req = (state_q == FETCH) && ready;
    vld_p0  = (state_q == POP);
  end

  // Stage p0: byte captured from the FIFO head at the pop.
  always_ff @(posedge clk) begin
    if (pop_req) byte_p0 <= data;
  end

  always_comb begin
    ext_c    = (parse_q == P_EXT) || (parse_q == P_EXTBRK);
    brk_c    = (parse_q == P_BRK) || (parse_q == P_EXTBRK);
    parse_d  = P_IDLE;
    do_make  = 1'b0;
    do_break = 1'b0;
    if (byte_p0 == 8'h00 || byte_p0 == 8'hFF)
      parse_d = P_IDLE;
    else if (byte_p0 == 8'hE0 && parse_q == P_IDLE)
      parse_d = P_EXT;
    else if (byte_p0 == 8'hF0 && parse_q == P_IDLE)
      parse_d = P_BRK;
    else if (byte_p0 == 8'hF0 && parse_q == P_EXT)
      parse_d = P_EXTBRK;
    else if (parse_q == P_IDLE &&
             (byte_p0 == 8'hAA || byte_p0 == 8'hFA || byte_p0 == 8'hEE))
      parse_d = P_IDLE;
    else begin
      do_make  = !brk_c;
      do_break = brk_c;
    end
    is_shift   = !ext_c && (byte_p0 == 8'h12 || byte_p0 == 8'h59);
    match      = key_held && (key_ext == ext_c) && (key_code == byte_p0);
    new_press  = do_make && !is_shift && !match;
    do_release = do_break && !is_shift && match;
    shift_set  = do_make && is_shift;
    shift_clr  = do_break && is_shift;
  end

  // Stage p1: key state and one-cycle event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      nextdata_n  <= 1'b1;
      parse_q     <= P_IDLE;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_ascii   <= 8'h00;
      key_held    <= 1'b0;
      shift       <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      press_count <= 8'h00;
    end else begin
      nextdata_n  <= !pop_req;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      if (vld_p0) begin
        parse_q <= parse_d;
        if (shift_set) shift <= 1'b1;
        if (shift_clr) shift <= 1'b0;
        if (new_press) begin
          key_code    <= byte_p0;
          key_ext     <= ext_c;
          key_held    <= 1'b1;
          key_ascii   <= ascii_map(byte_p0, ext_c, shift);
          key_press   <= 1'b1;
          press_count <= press_count + 8'h01;
        end
        if (do_release) begin
          key_held    <= 1'b0;
          key_release <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: table of bytes with hand-computed
// key state, plus sequences for reset mid-stream and a 256-press wrap stream.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       ready;
  logic       nextdata_n;
  logic [7:0] key_code;
  logic       key_ext;
  logic [7:0] key_ascii;
  logic       key_held;
  logic       shift;
  logic       key_press;
  logic       key_release;
  logic [7:0] press_count;

  ps2_scancode_decoder dut (
    .clk(clk), .rst(rst), .data(data), .ready(ready), .nextdata_n(nextdata_n),
    .key_code(key_code), .key_ext(key_ext), .key_ascii(key_ascii),
    .key_held(key_held), .shift(shift), .key_press(key_press),
    .key_release(key_release), .press_count(press_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic [7:0] code;
    logic       ext;
    logic [7:0] ascii;
    logic       held;
    logic       shf;
    logic       press;
    logic       rel;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  int dbl_low  = 0;
  logic prev_low = 1'b0;

  // Pop strobe monitor: counts pops and flags any strobe longer than one cycle.
  always @(negedge clk) begin
    if (!nextdata_n) begin
      pops <= pops + 1;
      if (prev_low) dbl_low <= dbl_low + 1;
    end
    prev_low <= !nextdata_n;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic [7:0] c, input logic e,
                              input logic [7:0] a, input logic h, input logic s,
                              input logic p, input logic r, input logic [7:0] n);
    vec_t v;
    v.din = d; v.code = c; v.ext = e; v.ascii = a; v.held = h;
    v.shf = s; v.press = p; v.rel = r; v.cnt = n;
    return v;
  endfunction

  function automatic logic [28:0] pack_exp(input vec_t v);
    return {v.code, v.ext, v.ascii, v.held, v.shf, v.press, v.rel, v.cnt};
  endfunction

  function automatic logic [28:0] pack_dut();
    return {key_code, key_ext, key_ascii, key_held, shift, key_press, key_release,
            press_count};
  endfunction

  // Presents one byte, waits for its pop, then returns at the negedge after E1
  // (outputs and pulses visible). Caller then steps one more negedge.
  task automatic send_byte(input logic [7:0] b, output logic ok);
    ok = 1'b0;
    @(negedge clk);
    data  = b;
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!nextdata_n) begin
        ok = 1'b1;
        break;
      end
    end
    ready = 1'b0;
    if (!ok) begin
      chk("pop_timeout", 32'd0, 32'd1);
      return;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst   = 1'b1;
    ready = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic ok;
    int   idx;
    int   cyc;
    rst   = 1'b1;
    ready = 1'b0;
    data  = 8'h00;

    vecs.push_back(mk(8'h1C, 8'h1C, 0, 8'h61, 1, 0, 1, 0, 8'd1));
    vecs.push_back(mk(8'hF0, 8'h1C, 0, 8'h61, 1, 0, 0, 0, 8'd1));
    vecs.push_back(mk(8'h1C, 8'h1C, 0, 8'h61, 0, 0, 0, 1, 8'd1));
    vecs.push_back(mk(8'h12, 8'h1C, 0, 8'h61, 0, 1, 0, 0, 8'd1));
    vecs.push_back(mk(8'h1C, 8'h1C, 0, 8'h41, 1, 1, 1, 0, 8'd2));
    vecs.push_back(mk(8'hF0, 8'h1C, 0, 8'h41, 1, 1, 0, 0, 8'd2));
    vecs.push_back(mk(8'h1C, 8'h1C, 0, 8'h41, 0, 1, 0, 1, 8'd2));
    vecs.push_back(mk(8'hF0, 8'h1C, 0, 8'h41, 0, 1, 0, 0, 8'd2));
    vecs.push_back(mk(8'h12, 8'h1C, 0, 8'h41, 0, 0, 0, 0, 8'd2));
    vecs.push_back(mk(8'hE0, 8'h1C, 0, 8'h41, 0, 0, 0, 0, 8'd2));
    vecs.push_back(mk(8'h75, 8'h75, 1, 8'h00, 1, 0, 1, 0, 8'd3));
    vecs.push_back(mk(8'hE0, 8'h75, 1, 8'h00, 1, 0, 0, 0, 8'd3));
    vecs.push_back(mk(8'h75, 8'h75, 1, 8'h00, 1, 0, 0, 0, 8'd3));
    vecs.push_back(mk(8'hE0, 8'h75, 1, 8'h00, 1, 0, 0, 0, 8'd3));
    vecs.push_back(mk(8'hF0, 8'h75, 1, 8'h00, 1, 0, 0, 0, 8'd3));
    vecs.push_back(mk(8'h75, 8'h75, 1, 8'h00, 0, 0, 0, 1, 8'd3));
    vecs.push_back(mk(8'hAA, 8'h75, 1, 8'h00, 0, 0, 0, 0, 8'd3));
    vecs.push_back(mk(8'h59, 8'h75, 1, 8'h00, 0, 1, 0, 0, 8'd3));
    vecs.push_back(mk(8'h32, 8'h32, 0, 8'h42, 1, 1, 1, 0, 8'd4));
    vecs.push_back(mk(8'h00, 8'h32, 0, 8'h42, 1, 1, 0, 0, 8'd4));
    vecs.push_back(mk(8'hF0, 8'h32, 0, 8'h42, 1, 1, 0, 0, 8'd4));
    vecs.push_back(mk(8'hFF, 8'h32, 0, 8'h42, 1, 1, 0, 0, 8'd4));
    vecs.push_back(mk(8'h32, 8'h32, 0, 8'h42, 1, 1, 0, 0, 8'd4));
    vecs.push_back(mk(8'hF0, 8'h32, 0, 8'h42, 1, 1, 0, 0, 8'd4));
    vecs.push_back(mk(8'h59, 8'h32, 0, 8'h42, 1, 0, 0, 0, 8'd4));
    vecs.push_back(mk(8'h45, 8'h45, 0, 8'h30, 1, 0, 1, 0, 8'd5));
    vecs.push_back(mk(8'h29, 8'h29, 0, 8'h20, 1, 0, 1, 0, 8'd6));
    vecs.push_back(mk(8'h5A, 8'h5A, 0, 8'h0D, 1, 0, 1, 0, 8'd7));
    vecs.push_back(mk(8'h66, 8'h66, 0, 8'h08, 1, 0, 1, 0, 8'd8));
    vecs.push_back(mk(8'hE0, 8'h66, 0, 8'h08, 1, 0, 0, 0, 8'd8));
    vecs.push_back(mk(8'h1C, 8'h1C, 1, 8'h00, 1, 0, 1, 0, 8'd9));
    vecs.push_back(mk(8'hF0, 8'h1C, 1, 8'h00, 1, 0, 0, 0, 8'd9));
    vecs.push_back(mk(8'h1C, 8'h1C, 1, 8'h00, 1, 0, 0, 0, 8'd9));

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_state", {nextdata_n, pack_dut()}, {1'b1, 29'd0});

    repeat (5) @(negedge clk);
    chk("idle_no_pop", {nextdata_n, pops}, {1'b1, 32'd0});

    for (int i = 0; i < vecs.size(); i++) begin
      send_byte(vecs[i].din, ok);
      if (ok) begin
        chk($sformatf("vec%0d_out", i), pack_dut(), pack_exp(vecs[i]));
        @(negedge clk);
        chk($sformatf("vec%0d_pulse_drop", i), {key_press, key_release}, 2'b00);
      end
    end
    chk("table_pops", pops, vecs.size());

    // Prefix already processed, then reset: next 1C must be a plain make.
    send_byte(8'hE0, ok);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_after_e0", {nextdata_n, pack_dut()}, {1'b1, 29'd0});
    send_byte(8'h1C, ok);
    chk("e0_lost_make", pack_dut(), pack_exp(mk(8'h1C, 8'h1C, 0, 8'h61, 1, 0, 1, 0, 8'd1)));
    @(negedge clk);

    // Reset landing during POP: the byte is discarded and not popped again.
    idx = pops;
    data  = 8'h1C;
    ready = 1'b1;
    @(negedge clk);
    chk("pop_before_rst", nextdata_n, 1'b0);
    rst   = 1'b1;
    ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_pop", {nextdata_n, pack_dut()}, {1'b1, 29'd0});
    repeat (4) @(negedge clk);
    chk("rst_in_pop_single", {nextdata_n, pops - idx}, {1'b1, 32'd1});

    // 256 alternating makes with ready held high: counter wraps to zero.
    do_reset(1);
    idx   = 0;
    data  = 8'h16;
    ready = 1'b1;
    for (cyc = 0; cyc < 1000 && idx < 256; cyc++) begin
      @(negedge clk);
      if (!nextdata_n) begin
        idx++;
        data = (idx % 2 == 1) ? 8'h1E : 8'h16;
      end
    end
    ready = 1'b0;
    chk("stream_pops", idx, 256);
    chk("stream_rate", cyc, 766);
    @(negedge clk);
    chk("stream_wrap", {key_code, key_ascii, key_held, press_count},
        {8'h1E, 8'h32, 1'b1, 8'h00});

    repeat (4) @(negedge clk);
    chk("total_pops", pops, vecs.size() + 3 + 256);
    chk("single_cycle_strobe", dbl_low, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
